// File: rtl/pc_pkg.sv
// rtl/pc_pkg.sv - shared PC source encodings and defaults for the PC/branch unit
package pc_pkg;

  typedef enum logic [1:0] {
    PC_SEQ = 2'b00,
    PC_BR  = 2'b01,
    PC_JMP = 2'b10,
    PC_RET = 2'b11
  } pcsrc_e;

  localparam int INSTR_BYTES = 2;

endpackage

// File: rtl/link_stack.sv
// rtl/link_stack.sv - circular link stack with top pointer, count, push/pop/swap
module link_stack #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] push_data,
  output logic [WIDTH-1:0] top_data,
  output logic [CW-1:0]    count,
  output logic             empty,
  output logic             full
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    tp;
  logic             do_pop;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign top_data = mem[tp];
  // A pop on an empty stack is a no-op here; the owner flags it.
  assign do_pop   = pop & ~empty;

  // Push+pop together swaps the top in place; a push when full wraps onto the oldest slot.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tp    <= '0;
      count <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (push && do_pop) begin
      mem[tp] <= push_data;
    end else if (push) begin
      tp                <= tp + PW'(1);
      mem[tp + PW'(1)]  <= push_data;
      if (!full) count  <= count + CW'(1);
    end else if (do_pop) begin
      tp    <= tp - PW'(1);
      count <= count - CW'(1);
    end
  end

endmodule

// File: rtl/pc_branch_unit.sv
// rtl/pc_branch_unit.sv - architectural PC, next-PC resolution, link stack and sticky errors
module pc_branch_unit
  import pc_pkg::*;
#(
  parameter int              WIDTH       = 16,
  parameter logic [WIDTH-1:0] RESET_PC   = '0,
  parameter int              INSTR_BYTES = pc_pkg::INSTR_BYTES,
  parameter int              STACK_DEPTH = 4,
  localparam int             CW          = $clog2(STACK_DEPTH) + 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             PCWrite,
  input  logic [1:0]       PCSrc,
  input  logic             PushLink,
  input  logic             ShouldBranch,
  input  logic [WIDTH-1:0] ALUOut,
  input  logic [WIDTH-1:0] Offset,
  input  logic             ClearErr,
  output logic [WIDTH-1:0] PC,
  output logic             BranchTaken,
  output logic [CW-1:0]    StackCount,
  output logic             StackOverflow,
  output logic             StackUnderflow,
  output logic             MisalignErr
);

  logic [WIDTH-1:0] seq_pc;
  logic [WIDTH-1:0] target;
  logic [WIDTH-1:0] next_pc;
  logic [WIDTH-1:0] top_data;
  logic             redirect;
  logic             is_ret;
  logic             stk_empty;
  logic             stk_full;
  logic             push;
  logic             pop;
  logic             ovf_ev;
  logic             unf_ev;
  logic             mis_ev;

  assign seq_pc = PC + WIDTH'(INSTR_BYTES);
  assign is_ret = (pcsrc_e'(PCSrc) == PC_RET);
  assign push   = PCWrite & PushLink;
  assign pop    = PCWrite & is_ret;

  // Select the next PC; redirect marks any non-sequential target actually taken.
  always_comb begin
    target   = seq_pc;
    redirect = 1'b0;
    case (pcsrc_e'(PCSrc))
      PC_SEQ: target = seq_pc;
      PC_BR: begin
        if (ShouldBranch) begin
          target   = PC + Offset;
          redirect = 1'b1;
        end
      end
      PC_JMP: begin
        target   = ALUOut;
        redirect = 1'b1;
      end
      PC_RET: begin
        if (!stk_empty) begin
          target   = top_data;
          redirect = 1'b1;
        end
      end
      default: target = seq_pc;
    endcase
  end

  // Redirected targets are forced halfword-aligned; the odd bit is reported instead.
  assign next_pc = {target[WIDTH-1:1], target[0] & ~redirect};
  assign mis_ev  = PCWrite & redirect & target[0];
  assign unf_ev  = pop & stk_empty;
  // A swap (push with a successful pop) never grows the stack, so it cannot overflow.
  assign ovf_ev  = push & stk_full & ~(is_ret & ~stk_empty);

  link_stack #(
    .WIDTH (WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_link_stack (
    .clk       (CLK),
    .rst_n     (RST_N),
    .push      (push),
    .pop       (pop),
    .push_data (seq_pc),
    .top_data  (top_data),
    .count     (StackCount),
    .empty     (stk_empty),
    .full      (stk_full)
  );

  // PC and redirect pulse advance only on enabled steps; sticky flags clear unless re-hit.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      PC             <= RESET_PC;
      BranchTaken    <= 1'b0;
      StackOverflow  <= 1'b0;
      StackUnderflow <= 1'b0;
      MisalignErr    <= 1'b0;
    end else begin
      if (PCWrite) PC <= next_pc;
      BranchTaken    <= PCWrite & redirect;
      StackOverflow  <= (StackOverflow  & ~ClearErr) | ovf_ev;
      StackUnderflow <= (StackUnderflow & ~ClearErr) | unf_ev;
      MisalignErr    <= (MisalignErr    & ~ClearErr) | mis_ev;
    end
  end

endmodule

// File: tb/tb_pc_branch_unit.sv
// tb/tb_pc_branch_unit.sv - directed self-checking bench for pc_branch_unit
module tb_pc_branch_unit;

  logic        CLK;
  logic        RST_N;
  logic        PCWrite;
  logic [1:0]  PCSrc;
  logic        PushLink;
  logic        ShouldBranch;
  logic [15:0] ALUOut;
  logic [15:0] Offset;
  logic        ClearErr;
  logic [15:0] PC;
  logic        BranchTaken;
  logic [2:0]  StackCount;
  logic        StackOverflow;
  logic        StackUnderflow;
  logic        MisalignErr;

  int compared   = 0;
  int mismatched = 0;

  pc_branch_unit dut (
    .CLK            (CLK),
    .RST_N          (RST_N),
    .PCWrite        (PCWrite),
    .PCSrc          (PCSrc),
    .PushLink       (PushLink),
    .ShouldBranch   (ShouldBranch),
    .ALUOut         (ALUOut),
    .Offset         (Offset),
    .ClearErr       (ClearErr),
    .PC             (PC),
    .BranchTaken    (BranchTaken),
    .StackCount     (StackCount),
    .StackOverflow  (StackOverflow),
    .StackUnderflow (StackUnderflow),
    .MisalignErr    (MisalignErr)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Apply one cycle of inputs, then sample 1 time unit after the capturing edge.
  task automatic step(input logic we, input logic [1:0] src, input logic pl, input logic sb,
                      input logic [15:0] alu, input logic [15:0] off, input logic clr);
    PCWrite      = we;
    PCSrc        = src;
    PushLink     = pl;
    ShouldBranch = sb;
    ALUOut       = alu;
    Offset       = off;
    ClearErr     = clr;
    @(posedge CLK);
    #1;
  endtask

  task automatic check_flags(input string tag, input logic ovf, input logic unf, input logic mis);
    check({tag, "_ovf"}, {31'd0, StackOverflow}, {31'd0, ovf});
    check({tag, "_unf"}, {31'd0, StackUnderflow}, {31'd0, unf});
    check({tag, "_mis"}, {31'd0, MisalignErr}, {31'd0, mis});
  endtask

  initial begin
    RST_N = 1'b0;
    PCWrite = 0; PCSrc = 2'b00; PushLink = 0; ShouldBranch = 0;
    ALUOut = '0; Offset = '0; ClearErr = 0;
    #12;
    check("rst_pc", PC, 32'h0000);
    check("rst_bt", BranchTaken, 0);
    check("rst_cnt", StackCount, 0);
    check_flags("rst", 0, 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    @(posedge CLK); #1;
    check("idle_pc", PC, 32'h0000);

    // Sequential stepping and hold
    step(1, 2'b00, 0, 0, 16'h0, 16'h0, 0); check("seq1", PC, 32'h0002);
    check("seq1_bt", BranchTaken, 0);
    step(1, 2'b00, 0, 0, 16'h0, 16'h0, 0); check("seq2", PC, 32'h0004);
    step(1, 2'b00, 0, 0, 16'h0, 16'h0, 0); check("seq3", PC, 32'h0006);
    step(0, 2'b00, 0, 0, 16'h0, 16'h0, 0); check("hold1", PC, 32'h0006);
    step(0, 2'b10, 0, 1, 16'h1234, 16'h0, 0); check("hold2", PC, 32'h0006);
    check("hold2_bt", BranchTaken, 0);

    // Conditional branch, taken and not taken; ShouldBranch ignored on jump
    step(1, 2'b10, 0, 0, 16'h0010, 16'h0, 0); check("jmp10", PC, 32'h0010);
    check("jmp10_bt", BranchTaken, 1);
    step(1, 2'b01, 0, 1, 16'h7777, 16'hFFF0, 0); check("br_t", PC, 32'h0000);
    check("br_t_bt", BranchTaken, 1);
    step(0, 2'b00, 0, 0, 16'h0, 16'h0, 0); check("br_t_pulse", BranchTaken, 0);
    step(1, 2'b10, 0, 0, 16'h0010, 16'h0, 0); check("jmp10b", PC, 32'h0010);
    step(1, 2'b01, 0, 0, 16'h7777, 16'hFFF0, 0); check("br_nt", PC, 32'h0012);
    check("br_nt_bt", BranchTaken, 0);

    // Wrap, misaligned jump, clear
    step(1, 2'b10, 0, 0, 16'hFFFE, 16'h0, 0); check("jmpfffe", PC, 32'hFFFE);
    step(1, 2'b00, 0, 0, 16'h0, 16'h0, 0); check("wrap", PC, 32'h0000);
    check("wrap_bt", BranchTaken, 0);
    step(1, 2'b10, 0, 0, 16'h1235, 16'h0, 0); check("mis_pc", PC, 32'h1234);
    check_flags("mis", 0, 0, 1);
    step(0, 2'b00, 0, 0, 16'h0, 16'h0, 1); check_flags("mis_clr", 0, 0, 0);
    check("mis_clr_pc", PC, 32'h1234);

    // Five calls into a four-entry stack
    step(1, 2'b10, 0, 0, 16'h0100, 16'h0, 0); check("go100", PC, 32'h0100);
    step(1, 2'b10, 1, 0, 16'h0200, 16'h0, 0); check("call1_cnt", StackCount, 1);
    step(1, 2'b10, 1, 0, 16'h0300, 16'h0, 0); check("call2_cnt", StackCount, 2);
    step(1, 2'b10, 1, 0, 16'h0400, 16'h0, 0); check("call3_cnt", StackCount, 3);
    step(1, 2'b10, 1, 0, 16'h0500, 16'h0, 0); check("call4_cnt", StackCount, 4);
    check_flags("call4", 0, 0, 0);
    step(1, 2'b10, 1, 0, 16'h0600, 16'h0, 0); check("call5_cnt", StackCount, 4);
    check_flags("call5", 1, 0, 0);
    check("call5_pc", PC, 32'h0600);
    step(1, 2'b11, 0, 0, 16'h0, 16'h0, 0); check("ret1", PC, 32'h0502);
    check("ret1_bt", BranchTaken, 1);
    check("ret1_cnt", StackCount, 3);
    step(1, 2'b11, 0, 0, 16'h0, 16'h0, 0); check("ret2", PC, 32'h0402);
    step(1, 2'b11, 0, 0, 16'h0, 16'h0, 0); check("ret3", PC, 32'h0302);
    step(1, 2'b11, 0, 0, 16'h0, 16'h0, 0); check("ret4", PC, 32'h0202);
    check("ret4_cnt", StackCount, 0);
    step(1, 2'b11, 0, 0, 16'h0, 16'h0, 0); check("ret5", PC, 32'h0204);
    check("ret5_bt", BranchTaken, 0);
    check_flags("ret5", 1, 1, 0);
    step(0, 2'b00, 0, 0, 16'h0, 16'h0, 1); check_flags("stk_clr", 0, 0, 0);
    // Clear loses to a new underflow in the same cycle
    step(1, 2'b11, 0, 0, 16'h0, 16'h0, 1); check_flags("clr_vs_unf", 0, 1, 0);
    check("clr_vs_unf_pc", PC, 32'h0206);

    // Push + return in one step swaps the top
    step(1, 2'b10, 0, 0, 16'h0040, 16'h0, 0); check("go40", PC, 32'h0040);
    step(1, 2'b10, 1, 0, 16'h0800, 16'h0, 0); check("call40_pc", PC, 32'h0800);
    check("call40_cnt", StackCount, 1);
    step(1, 2'b11, 1, 0, 16'h0, 16'h0, 0); check("swap_pc", PC, 32'h0042);
    check("swap_cnt", StackCount, 1);
    check("swap_bt", BranchTaken, 1);
    step(1, 2'b11, 0, 0, 16'h0, 16'h0, 0); check("swap_top", PC, 32'h0802);
    check("swap_top_cnt", StackCount, 0);
    step(0, 2'b00, 0, 0, 16'h0, 16'h0, 1); check_flags("clr2", 0, 0, 0);
    // Push + return on empty stack: sequential, underflow, push lands
    step(1, 2'b11, 1, 0, 16'h0, 16'h0, 0); check("swap_e_pc", PC, 32'h0804);
    check("swap_e_cnt", StackCount, 1);
    check_flags("swap_e", 0, 1, 0);
    step(1, 2'b11, 0, 0, 16'h0, 16'h0, 0); check("swap_e_top", PC, 32'h0804);
    // Push alongside a plain sequential step
    step(1, 2'b00, 1, 0, 16'h0, 16'h0, 0); check("seqpush_pc", PC, 32'h0806);
    check("seqpush_cnt", StackCount, 1);
    check("seqpush_bt", BranchTaken, 0);

    // Asynchronous reset between edges
    #2;
    RST_N = 1'b0;
    #1;
    check("arst_pc", PC, 32'h0000);
    check("arst_cnt", StackCount, 0);
    check_flags("arst", 0, 0, 0);
    @(negedge CLK);
    RST_N = 1'b1;
    step(1, 2'b11, 0, 0, 16'h0, 16'h0, 0); check("arst_ret_pc", PC, 32'h0002);
    check_flags("arst_ret", 0, 1, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
